// File: rtl/hermes_pkg.sv
// hermes_pkg: shared types and constants for the Hermes packet transmitter.
// Optional build macro HERMES_TX_LFSR_EN is consumed by hermes_payload_gen.
package hermes_pkg;

    // Default flit width; also the width of the size field
    localparam int unsigned FLIT_W_DEF = 16;

    // Router port indices
    localparam int unsigned EAST  = 0;
    localparam int unsigned WEST  = 1;
    localparam int unsigned NORTH = 2;
    localparam int unsigned SOUTH = 3;
    localparam int unsigned LOCAL = 4;

    // Fibonacci LFSR taps 16,15,13,4 expressed as a bit mask (bits 15,14,12,3)
    localparam logic [15:0] LFSR_TAPS = 16'hD008;

    // Transmitter FSM states
    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_SIZE,
        S_PAYLOAD,
        S_GAP
    } tx_fsm_type;

endpackage

// File: rtl/hermes_pkt_tx_if.sv
// hermes_pkt_tx_if: credit-based flit link between the transmitter and a
// router input port (tx -> rx, data_out -> data_in, credit_o -> credit_i).
interface hermes_pkt_tx_if #(
    parameter int unsigned FLIT_W = 16
);

    logic              tx;
    logic [FLIT_W-1:0] data_out;
    logic              credit_i;

    // Sending end (the transmitter)
    modport master (
        output tx,
        output data_out,
        input  credit_i
    );

    // Receiving end (the router input buffer)
    modport slave (
        input  tx,
        input  data_out,
        output credit_i
    );

endinterface

// File: rtl/hermes_payload_gen.sv
// hermes_payload_gen: payload word register for hermes_pkt_tx.
// Default build advances by +1 (mod 2^FLIT_W). With HERMES_TX_LFSR_EN defined
// it advances as a Fibonacci LFSR (shift left, feedback into bit 0) and a zero
// seed is replaced by 1 at load so the sequence never locks up.
module hermes_payload_gen
    import hermes_pkg::*;
#(
    parameter int unsigned FLIT_W = FLIT_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_advance,
    input  logic [FLIT_W-1:0] i_seed,
    output logic [FLIT_W-1:0] o_value
);

    logic [FLIT_W-1:0] r_value;
    logic [FLIT_W-1:0] w_next;
    logic [FLIT_W-1:0] w_load_val;

`ifdef HERMES_TX_LFSR_EN
    logic [FLIT_W-1:0] w_taps;
    logic              w_fb;

    // LFSR successor and zero-seed substitution
    always_comb begin
        w_taps     = FLIT_W'(LFSR_TAPS);
        w_fb       = ^(r_value & w_taps);
        w_next     = {r_value[FLIT_W-2:0], w_fb};
        w_load_val = (i_seed == '0) ? FLIT_W'(1) : i_seed;
    end
`else
    // Incrementing successor; seed is used as-is
    always_comb begin
        w_next     = r_value + FLIT_W'(1);
        w_load_val = i_seed;
    end
`endif

    // Payload register: load on accepted start, advance on each payload transfer
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= w_load_val;
        end else if (i_advance) begin
            r_value <= w_next;
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/hermes_pkt_tx.sv
// hermes_pkt_tx: credit-based Hermes packet transmitter (header, size, payload).
// Optional build macro HERMES_TX_LFSR_EN selects an LFSR payload sequence
// (implemented in hermes_payload_gen); default build uses incrementing payload.
module hermes_pkt_tx
    import hermes_pkg::*;
#(
    parameter int unsigned FLIT_W  = FLIT_W_DEF,
    parameter int unsigned GAP_CYC = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [FLIT_W-1:0]   target,
    input  logic [FLIT_W-1:0]   size,
    input  logic [FLIT_W-1:0]   seed,
    hermes_pkt_tx_if.master     link,
    output logic                busy,
    output logic                done,
    output logic [15:0]         pkt_cnt
);

    // S_GAP always lasts at least one cycle (the done cycle)
    localparam int unsigned GAP_LAST = (GAP_CYC > 1) ? (GAP_CYC - 1) : 0;

    tx_fsm_type        r_state;
    tx_fsm_type        w_state_nxt;

    logic [FLIT_W-1:0] r_target;
    logic [FLIT_W-1:0] r_size;
    logic [FLIT_W-1:0] r_rem;
    logic [15:0]       r_gap_cnt;
    logic              r_done;
    logic [15:0]       r_pkt_cnt;

    logic              w_tx;
    logic [FLIT_W-1:0] w_data;
    logic              w_accept;
    logic              w_advance;
    logic              w_pkt_end;
    logic              w_gap_last;
    logic [FLIT_W-1:0] w_payload;

    assign w_gap_last = (r_gap_cnt == 16'(GAP_LAST));

    hermes_payload_gen #(
        .FLIT_W (FLIT_W)
    ) u_payload_gen (
        .clock     (clock),
        .reset     (reset),
        .i_load    (w_accept),
        .i_advance (w_advance),
        .i_seed    (seed),
        .o_value   (w_payload)
    );

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and link outputs; tx/data depend only on state so they hold under backpressure
    always_comb begin
        w_state_nxt = r_state;
        w_tx        = 1'b0;
        w_data      = '0;
        w_accept    = 1'b0;
        w_advance   = 1'b0;
        w_pkt_end   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_HEADER;
                end
            end
            S_HEADER: begin
                w_tx   = 1'b1;
                w_data = r_target;
                if (link.credit_i) begin
                    w_state_nxt = S_SIZE;
                end
            end
            S_SIZE: begin
                w_tx   = 1'b1;
                w_data = r_size;
                if (link.credit_i) begin
                    if (r_size == '0) begin
                        w_pkt_end   = 1'b1;
                        w_state_nxt = S_GAP;
                    end else begin
                        w_state_nxt = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                w_tx   = 1'b1;
                w_data = w_payload;
                if (link.credit_i) begin
                    w_advance = 1'b1;
                    if (r_rem == FLIT_W'(1)) begin
                        w_pkt_end   = 1'b1;
                        w_state_nxt = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (w_gap_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Packet fields captured on accepted start; remaining count tracks payload transfers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_target <= '0;
            r_size   <= '0;
            r_rem    <= '0;
        end else if (w_accept) begin
            r_target <= target;
            r_size   <= size;
            r_rem    <= size;
        end else if (w_advance) begin
            r_rem    <= r_rem - FLIT_W'(1);
        end
    end

    // Gap counter: restarts on packet end, counts while in S_GAP
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_gap_cnt <= '0;
        end else if (w_pkt_end) begin
            r_gap_cnt <= '0;
        end else if ((r_state == S_GAP) && !w_gap_last) begin
            r_gap_cnt <= r_gap_cnt + 16'd1;
        end
    end

    // Done pulse and packet counter, both updated by the final transfer
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_done    <= 1'b0;
            r_pkt_cnt <= '0;
        end else begin
            r_done <= w_pkt_end;
            if (w_pkt_end) begin
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
        end
    end

    assign link.tx       = w_tx;
    assign link.data_out = w_data;
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign pkt_cnt       = r_pkt_cnt;

endmodule

// File: tb/tb_hermes_pkt_tx.sv
// tb_hermes_pkt_tx: directed and randomized checks of hermes_pkt_tx against a
// flit-list reference model (header, size, then payload sequence).
module tb_hermes_pkt_tx;

    localparam int unsigned G = 2;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] target;
    logic [15:0] size;
    logic [15:0] seed;
    logic        busy;
    logic        done;
    logic [15:0] pkt_cnt;

    int          total;
    int          bad;
    logic [15:0] exp_cnt;

    hermes_pkt_tx_if #(.FLIT_W(16)) link ();

    hermes_pkt_tx #(
        .FLIT_W  (16),
        .GAP_CYC (G)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .target   (target),
        .size     (size),
        .seed     (seed),
        .link     (link),
        .busy     (busy),
        .done     (done),
        .pkt_cnt  (pkt_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] next_pl(input logic [15:0] x);
`ifdef HERMES_TX_LFSR_EN
        return {x[14:0], x[15] ^ x[14] ^ x[12] ^ x[3]};
`else
        return x + 16'd1;
`endif
    endfunction

    function automatic logic [15:0] first_pl(input logic [15:0] s);
`ifdef HERMES_TX_LFSR_EN
        return (s == 16'd0) ? 16'd1 : s;
`else
        return s;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One packet from the idle state; caller is at a negedge with busy low.
    task automatic send_pkt(input logic [15:0] tgt, input logic [15:0] sz, input logic [15:0] sd,
                            input int hold_idx, input int hold_len, input bit rnd, input bit collide);
        logic [15:0] exp_q[$];
        logic [15:0] pl;
        int          idx;
        int          cyc;
        int          held;
        int          gap;
        bit          cr;
        bit          did;
        exp_q = {};
        exp_q.push_back(tgt);
        exp_q.push_back(sz);
        pl = first_pl(sd);
        for (int i = 0; i < int'(sz); i++) begin
            exp_q.push_back(pl);
            pl = next_pl(pl);
        end

        check("idle_busy", busy, 1'b0);
        start  = 1'b1;
        target = tgt;
        size   = sz;
        seed   = sd;
        @(negedge clock);
        start = 1'b0;
        check("first_tx_latency", link.tx, 1'b1);

        idx  = 0;
        cyc  = 0;
        held = 0;
        did  = 1'b0;
        while (idx < exp_q.size() && cyc < 400) begin
            check("tx_high", link.tx, 1'b1);
            check("data_out", link.data_out, exp_q[idx]);
            check("busy_in_pkt", busy, 1'b1);
            check("done_in_pkt", done, 1'b0);
            cr = 1'b1;
            if (rnd) cr = ($urandom_range(0, 3) != 0);
            if (idx == hold_idx && held < hold_len) begin
                cr = 1'b0;
                held++;
            end
            link.credit_i = cr;
            start = 1'b0;
            if (collide && !did && idx >= 3) begin
                start  = 1'b1;
                target = 16'hDEAD;
                size   = 16'h0007;
                seed   = 16'h5555;
                did    = 1'b1;
            end
            @(negedge clock);
            cyc++;
            if (cr) idx++;
        end
        start = 1'b0;
        check("pkt_flits_within_budget", idx, exp_q.size());
        if (hold_len > 0) check("hold_cycles_applied", held, hold_len);

        exp_cnt = exp_cnt + 16'd1;
        check("done_pulse", done, 1'b1);
        check("tx_low_gap", link.tx, 1'b0);
        check("busy_gap", busy, 1'b1);
        check("pkt_cnt_done", pkt_cnt, exp_cnt);

        gap = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            check("done_one_cycle", done, 1'b0);
            if (!busy) break;
            gap++;
        end
        check("gap_len", gap, (G == 0) ? 1 : G);
        check("pkt_cnt_after", pkt_cnt, exp_cnt);
    endtask

    initial begin
        logic [15:0] p;
        total         = 0;
        bad           = 0;
        exp_cnt       = 16'd0;
        reset         = 1'b0;
        start         = 1'b0;
        target        = 16'd0;
        size          = 16'd0;
        seed          = 16'd0;
        link.credit_i = 1'b1;

        #1;
        check("rst_tx", link.tx, 1'b0);
        check("rst_data", link.data_out, 16'h0000);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pkt_cnt", pkt_cnt, 16'h0000);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Basic packet
        send_pkt(16'h0012, 16'd1, 16'h0002, -1, 0, 1'b0, 1'b0);
        // Backpressure on the second payload flit (flit index 3)
        send_pkt(16'h0021, 16'd3, 16'h00A0, 3, 4, 1'b0, 1'b0);
        // Zero size
        send_pkt(16'h0033, 16'd0, 16'h1234, -1, 0, 1'b0, 1'b0);
        // Wrap-around
        send_pkt(16'h0044, 16'd3, 16'hFFFE, -1, 0, 1'b0, 1'b0);
`ifdef HERMES_TX_LFSR_EN
        send_pkt(16'h0045, 16'd2, 16'h0000, -1, 0, 1'b0, 1'b0);
`endif
        // Start collision during payload, then a fresh accepted start
        send_pkt(16'h0055, 16'd4, 16'h0300, -1, 0, 1'b0, 1'b1);
        send_pkt(16'h0056, 16'd2, 16'h0400, -1, 0, 1'b0, 1'b0);

        // Randomized packets with random credit
        for (int n = 0; n < 6; n++) begin
            send_pkt(16'($urandom), 16'($urandom_range(0, 5)), 16'($urandom), -1, 0, 1'b1, 1'b0);
        end

        // Reset mid-packet
        link.credit_i = 1'b1;
        start  = 1'b1;
        target = 16'h0066;
        size   = 16'd6;
        seed   = 16'h0010;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        p = next_pl(next_pl(first_pl(16'h0010)));
        check("mid_pkt_tx", link.tx, 1'b1);
        check("mid_pkt_data", link.data_out, p);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_tx", link.tx, 1'b0);
        check("async_rst_data", link.data_out, 16'h0000);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_pkt_cnt", pkt_cnt, 16'h0000);
        check("async_rst_done", done, 1'b0);
        exp_cnt = 16'd0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("post_rst_done", done, 1'b0);
        check("post_rst_busy", busy, 1'b0);
        send_pkt(16'h0077, 16'd2, 16'h0900, -1, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hermes_pkt_tx.md
Name: hermes_pkt_tx

Overview:
- Credit-based flit transmitter that injects Hermes packets into a router input port, normally the LOCAL port.
- It is the sending end of the rx/data_in/credit_o interface that the router input buffer exposes.
- Packet format: header flit (target address XY), size flit (payload flit count), then the payload flits.
- Used as a traffic source in simulation and formal benches.

Parameters:
- FLIT_W, 16, flit width in bits; also the width of the size field.
- GAP_CYC, 2, idle cycles inserted after each packet before the block can go busy again; 0 is legal.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous reset, active-low; asserted when reset==0.
- start  in  1  packet request; sampled only in S_IDLE.
- target  in  FLIT_W  header flit value, e.g. 16'h0012 for x=1, y=2; captured on accepted start.
- size  in  FLIT_W  payload flit count; captured on accepted start.
- seed  in  FLIT_W  first payload value; captured on accepted start.
- tx  out  1  flit valid toward the router (router side: rx).
- data_out  out  FLIT_W  flit data (router side: data_in).
- credit_i  in  1  router has buffer space (router side: credit_o).
- busy  out  1  high from accepted start through the end of the gap.
- done  out  1  one-cycle pulse in the cycle after the last flit transfers.
- pkt_cnt  out  16  number of packets completed; wraps modulo 2^16.

Behaviour:
- Reset (reset==0, asynchronous): all registers clear. tx=0, data_out=0, busy=0, done=0, pkt_cnt=0, state=S_IDLE.
- Transfer rule: a flit moves in a cycle where tx==1 and credit_i==1 at the clock edge.
- Holding rule: while tx==1 and credit_i==0, data_out and tx hold stable. tx never drops without a transfer.
- FSM states: S_IDLE, S_HEADER, S_SIZE, S_PAYLOAD, S_GAP.
- S_IDLE:
  - tx=0, busy=0.
  - start==1 captures target, size and seed, loads remaining count rem=size, and moves to S_HEADER next cycle.
  - Start-to-first-tx latency is 1 cycle.
- S_HEADER: tx=1, data_out=target. On transfer, go to S_SIZE.
- S_SIZE: tx=1, data_out=size.
  - On transfer with size==0: go to S_GAP and pulse done.
  - Otherwise go to S_PAYLOAD.
- S_PAYLOAD:
  - tx=1, data_out=current payload word; the first payload word is seed.
  - On each transfer: advance the payload word and decrement rem.
  - On the transfer with rem==1: go to S_GAP and pulse done.
- Payload advance: next = current + 1, modulo 2^FLIT_W (0xFFFF wraps to 0x0000).
- done: registered; high for exactly 1 cycle, the first cycle of S_GAP. pkt_cnt increments on that same cycle.
- S_GAP:
  - tx=0, busy=1.
  - Stay GAP_CYC cycles, then return to S_IDLE.
  - With GAP_CYC=0, S_GAP lasts 1 cycle: the cycle done is high.
- start while busy: ignored, no queuing. The requester must wait for busy==0.
- start and credit_i are independent; credit_i may be low for any number of cycles. No timeout.
- Reset mid-packet: the packet is abandoned and tx drops immediately on reset. pkt_cnt is not incremented for that packet and clears to 0 with reset.
- Size width: size up to 2^FLIT_W-1 is legal; rem is FLIT_W bits.
- Packet length in flits = size+2. The minimum cycle count between starts is size+2+max(GAP_CYC,1)+1 with continuous credit.

Optional Feature:
- Macro: HERMES_TX_LFSR_EN.
- Defined: the payload advance is a Fibonacci LFSR instead of +1.
  - Width FLIT_W; taps for 16 bits are 16,15,13,4; shift left, feedback into bit 0.
  - seed==0 is replaced by 16'h0001 at capture, so the LFSR never locks at zero.
  - Header and size flits are unchanged.
- Undefined: incrementing payload as specified above. There is no LFSR logic.

Decomposition:
- Package hermes_pkg:
  - typedef enum tx_fsm_type {S_IDLE, S_HEADER, S_SIZE, S_PAYLOAD, S_GAP};
  - port index constants EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4;
  - FLIT_W default constant;
  - LFSR tap constant.
- One sub-module: hermes_payload_gen.
  - Holds the payload register with load (seed) and advance inputs.
  - Selects increment or LFSR under HERMES_TX_LFSR_EN.
- The FSM, remaining counter, gap counter and pkt_cnt stay in hermes_pkt_tx.

Test Plan:
- Basic packet: credit_i=1 constant; start with target=16'h0012, size=1, seed=16'h0002. Required: tx high for 3 consecutive cycles starting 1 cycle after start, data_out 0012, 0001, 0002; done pulses the next cycle; pkt_cnt=1; busy low after GAP_CYC=2.
- Backpressure: size=3, seed=16'h00A0; credit_i low for 4 cycles during the second payload flit. Required: data_out holds 00A1 with tx=1 throughout; sequence 00A0, 00A1, 00A2 delivered with no duplicates or drops.
- Zero size: size=0. Required: exactly 2 flits (header, 0000), then done; payload generator untouched.
- Wrap-around: seed=16'hFFFE, size=3. Required: payload FFFE, FFFF, 0000. With HERMES_TX_LFSR_EN and seed=0: first payload 0001.
- Busy/start collision: pulse start again during S_PAYLOAD. Required: the second request is ignored. After busy falls, a new start is accepted; pkt_cnt increments by 1 per completed packet only.
- Reset mid-packet: assert reset during S_PAYLOAD. Required: tx=0 asynchronously; pkt_cnt=0; state=S_IDLE; no done pulse; a fresh start afterwards produces a complete packet.
